// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART serialiser with a valid/ready byte intake.
// Frame on TxBit: start 0, 8 data bits LSB first, [even parity], stop 1.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity cell
// between the last data bit and the stop bit. Default build has no parity.
module uart_transmitter #(
  parameter int CLK_FREQ     = 27000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TxBit,
  output logic       busy
);

  // A cell counter needs at least one bit even for degenerate rates.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CELL_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_e;
`endif

  state_e        state_q;
  logic [CW-1:0] cell_q;
  logic [CW-1:0] cell_d;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txbit_q;
  logic          busy_q;
  logic          cell_done;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  // Terminal count of the current bit cell and the wrapped next count.
  always_comb begin
    cell_done = (cell_q == CELL_LAST);
    cell_d    = cell_done ? '0 : cell_q + 1'b1;
  end

  // Intake is open only while the line is idle.
  assign tx_ready = (state_q == S_IDLE);
  assign TxBit    = txbit_q;
  assign busy     = busy_q;

  // Frame sequencer: every output is registered so TxBit is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cell_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txbit_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // Byte is captured here; later tx_data changes cannot touch the frame.
          if (tx_valid) begin
            shift_q  <= tx_data;
            bit_q    <= '0;
            cell_q   <= '0;
            state_q  <= S_START;
            txbit_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^tx_data;
`endif
          end
        end

        S_START: begin
          cell_q <= cell_d;
          if (cell_done) begin
            state_q <= S_DATA;
            txbit_q <= shift_q[0];
          end
        end

        S_DATA: begin
          cell_q <= cell_d;
          if (cell_done) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              txbit_q <= parity_q;
`else
              state_q <= S_STOP;
              txbit_q <= 1'b1;
`endif
            end else begin
              // shift_q[0] is the bit on the line now; [1] is the next one.
              txbit_q <= shift_q[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          cell_q <= cell_d;
          if (cell_done) begin
            state_q <= S_STOP;
            txbit_q <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          cell_q <= cell_d;
          if (cell_done) begin
            // Line stays high; at least one IDLE cycle separates frames.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          txbit_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
